// File: rtl/chip_reset_ctrl.sv
// chip_reset_ctrl
//   Chip-wide reset sequencer behind the clock-generation stage. Waits for a
//   filtered DCM lock, stretches reset for HOLD_CYCLES, then releases
//   chip_reset_ synchronously to clk. Reset is re-asserted on lock loss or on
//   a debounced push-switch press while running.
//
// Ports
//   clk          system clock (DCM CLK0)
//   reset_       async active-low power-on reset
//   locked_in    DCM lock, async to clk, 1 = locked
//   sw_reset_    raw push-switch, async, 0 = pressed
//   chip_reset_  registered system reset, active-low
//   reset_state  FSM state: 0 WAIT_LOCK, 1 HOLD, 2 RUN, 3 SW_RST
//   lock_lost    sticky, lock dropped while in RUN
//   reset_count  saturating count of reset events taken from RUN

module chip_reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];
endmodule

module chip_reset_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_FILTER     = 16,
  parameter int HOLD_CYCLES     = 255,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       locked_in,
  input  logic       sw_reset_,
  output logic       chip_reset_,
  output logic [1:0] reset_state,
  output logic       lock_lost,
  output logic [7:0] reset_count
);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2,
    ST_SW_RST    = 2'd3
  } state_e;

  localparam logic [7:0]  FILT_MAX  = 8'(LOCK_FILTER);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  CNT_MAX   = 8'hFF;

  // ---------------------------------------------------------------------------
  // Input synchronizers. The switch is inverted ahead of the chain so that the
  // cleared flops read as "not pressed" straight out of reset.
  // ---------------------------------------------------------------------------
  logic lock_sync;
  logic sw_sync;

  chip_reset_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk    (clk),
    .reset_ (reset_),
    .d_i    (locked_in),
    .q_o    (lock_sync)
  );

  chip_reset_sync #(.STAGES(SYNC_STAGES)) u_sw_sync (
    .clk    (clk),
    .reset_ (reset_),
    .d_i    (~sw_reset_),
    .q_o    (sw_sync)
  );

  // ---------------------------------------------------------------------------
  // Lock filter: counts consecutive high samples, saturating at LOCK_FILTER.
  // Any low sample throws away all accumulated credit.
  // ---------------------------------------------------------------------------
  logic [7:0] filt_q, filt_d;
  logic       lock_ok;

  always_comb begin
    filt_d = filt_q;
    if (!lock_sync)            filt_d = '0;
    else if (filt_q != FILT_MAX) filt_d = filt_q + 8'd1;
  end

  assign lock_ok = (filt_q == FILT_MAX);

  // ---------------------------------------------------------------------------
  // Switch debounce: sw_db only flips after DEBOUNCE_CYCLES consecutive
  // samples that disagree with it; a single agreeing sample restarts the run.
  // ---------------------------------------------------------------------------
  logic [15:0] db_cnt_q, db_cnt_d;
  logic        sw_db_q, sw_db_d;

  always_comb begin
    db_cnt_d = '0;
    sw_db_d  = sw_db_q;
    if (sw_sync != sw_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        sw_db_d  = sw_sync;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       chip_rst_q, chip_rst_d;
  logic       lock_lost_q, lock_lost_d;
  logic [7:0] count_q, count_d;
  logic       run_lock_drop;   // RUN exit caused by lock loss
  logic       run_exit;        // any counted exit from RUN

  // State register and all sequential state
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_WAIT_LOCK;
      hold_q      <= '0;
      filt_q      <= '0;
      db_cnt_q    <= '0;
      sw_db_q     <= 1'b0;
      chip_rst_q  <= 1'b0;
      lock_lost_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      filt_q      <= filt_d;
      db_cnt_q    <= db_cnt_d;
      sw_db_q     <= sw_db_d;
      chip_rst_q  <= chip_rst_d;
      lock_lost_q <= lock_lost_d;
      count_q     <= count_d;
    end
  end

  // Next-state logic. Lock loss always outranks the switch.
  always_comb begin
    state_d       = state_q;
    run_lock_drop = 1'b0;
    run_exit      = 1'b0;
    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_ok) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!lock_sync)              state_d = ST_WAIT_LOCK;
        else if (hold_q == HOLD_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_sync) begin
          state_d       = ST_WAIT_LOCK;
          run_lock_drop = 1'b1;
          run_exit      = 1'b1;
        end else if (sw_db_q) begin
          state_d  = ST_SW_RST;
          run_exit = 1'b1;
        end
      end
      ST_SW_RST: begin
        if (!lock_sync)    state_d = ST_WAIT_LOCK;
        else if (!sw_db_q) state_d = ST_HOLD;
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  // Output / registered-status logic. The hold counter only advances while
  // staying in HOLD, so every entry into HOLD starts from zero.
  always_comb begin
    hold_d      = (state_q == ST_HOLD && state_d == ST_HOLD) ? hold_q + 8'd1 : 8'd0;
    chip_rst_d  = (state_d == ST_RUN);
    lock_lost_d = lock_lost_q | run_lock_drop;
    count_d     = (run_exit && count_q != CNT_MAX) ? count_q + 8'd1 : count_q;
  end

  assign chip_reset_ = chip_rst_q;
  assign reset_state = state_q;
  assign lock_lost   = lock_lost_q;
  assign reset_count = count_q;

endmodule

// File: tb/tb_chip_reset_ctrl.sv
module tb_chip_reset_ctrl;
  logic       clk = 1'b0;
  logic       reset_;
  logic       locked_in;
  logic       sw_reset_;
  logic       chip_reset_;
  logic [1:0] reset_state;
  logic       lock_lost;
  logic [7:0] reset_count;

  int checks = 0;
  int errors = 0;

  chip_reset_ctrl #(
    .SYNC_STAGES     (2),
    .LOCK_FILTER     (4),
    .HOLD_CYCLES     (8),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset_      (reset_),
    .locked_in   (locked_in),
    .sw_reset_   (sw_reset_),
    .chip_reset_ (chip_reset_),
    .reset_state (reset_state),
    .lock_lost   (lock_lost),
    .reset_count (reset_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; sample/drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_ = 1'b0; locked_in = 1'b1; sw_reset_ = 1'b1;
    repeat (3) tick();
    checks++;
    if (reset_state !== 2'd0 || chip_reset_ !== 1'b0 || lock_lost !== 1'b0 || reset_count !== 8'd0) begin
      errors++;
      $display("FAIL reset: state=%0d chip=%b lost=%b cnt=%0d expected 0 0 0 0",
               reset_state, chip_reset_, lock_lost, reset_count);
    end
  endtask

  task automatic test_powerup();
    logic [1:0] es;
    reset_ = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      es = (e <= 6) ? 2'd0 : (e <= 14) ? 2'd1 : 2'd2;
      checks++;
      if (reset_state !== es || chip_reset_ !== (e == 15)) begin
        errors++;
        $display("FAIL powerup e%0d: state=%0d chip=%b expected state=%0d chip=%b",
                 e, reset_state, chip_reset_, es, (e == 15));
      end
    end
  endtask

  task automatic test_switch();
    logic [1:0] es;
    // Two-cycle bounces must never reach sw_db
    for (int b = 0; b < 3; b++) begin
      sw_reset_ = 1'b0; tick(); tick();
      sw_reset_ = 1'b1; tick(); tick();
    end
    repeat (4) tick();
    checks++;
    if (reset_state !== 2'd2 || chip_reset_ !== 1'b1 || reset_count !== 8'd0) begin
      errors++;
      $display("FAIL bounce: state=%0d chip=%b cnt=%0d expected 2 1 0", reset_state, chip_reset_, reset_count);
    end
    sw_reset_ = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      es = (e < 7) ? 2'd2 : 2'd3;
      checks++;
      if (reset_state !== es || chip_reset_ !== (e < 7)) begin
        errors++;
        $display("FAIL press e%0d: state=%0d chip=%b expected state=%0d chip=%b",
                 e, reset_state, chip_reset_, es, (e < 7));
      end
    end
    checks++;
    if (reset_count !== 8'd1) begin
      errors++;
      $display("FAIL press_count: cnt=%0d expected 1", reset_count);
    end
    sw_reset_ = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      es = (e < 7) ? 2'd3 : (e < 15) ? 2'd1 : 2'd2;
      checks++;
      if (reset_state !== es || chip_reset_ !== (e == 15)) begin
        errors++;
        $display("FAIL release e%0d: state=%0d chip=%b expected state=%0d chip=%b",
                 e, reset_state, chip_reset_, es, (e == 15));
      end
    end
  endtask

  task automatic test_lock_loss_sw_rst();
    sw_reset_ = 1'b0;
    repeat (7) tick();
    checks++;
    if (reset_state !== 2'd3 || reset_count !== 8'd2) begin
      errors++;
      $display("FAIL swrst_enter: state=%0d cnt=%0d expected 3 2", reset_state, reset_count);
    end
    locked_in = 1'b0;
    tick(); tick();
    checks++;
    if (reset_state !== 2'd3) begin
      errors++;
      $display("FAIL swrst_lock_early: state=%0d expected 3", reset_state);
    end
    tick();
    checks++;
    if (reset_state !== 2'd0 || reset_count !== 8'd2 || lock_lost !== 1'b0 || chip_reset_ !== 1'b0) begin
      errors++;
      $display("FAIL swrst_lock: state=%0d cnt=%0d lost=%b chip=%b expected 0 2 0 0",
               reset_state, reset_count, lock_lost, chip_reset_);
    end
    sw_reset_ = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_lock_loss_hold();
    logic [1:0] es;
    locked_in = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      es = (e <= 6) ? 2'd0 : 2'd1;
      checks++;
      if (reset_state !== es) begin
        errors++;
        $display("FAIL hold_enter e%0d: state=%0d expected %0d", e, reset_state, es);
      end
    end
    locked_in = 1'b0;
    tick(); tick();
    checks++;
    if (reset_state !== 2'd1) begin
      errors++;
      $display("FAIL hold_lock_early: state=%0d expected 1", reset_state);
    end
    tick();
    checks++;
    if (reset_state !== 2'd0 || reset_count !== 8'd2 || lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL hold_lock: state=%0d cnt=%0d lost=%b expected 0 2 0", reset_state, reset_count, lock_lost);
    end
    locked_in = 1'b1;
    repeat (14) tick();
    checks++;
    if (reset_state !== 2'd1 || chip_reset_ !== 1'b0) begin
      errors++;
      $display("FAIL hold_restore14: state=%0d chip=%b expected 1 0", reset_state, chip_reset_);
    end
    tick();
    checks++;
    if (reset_state !== 2'd2 || chip_reset_ !== 1'b1) begin
      errors++;
      $display("FAIL hold_restore15: state=%0d chip=%b expected 2 1", reset_state, chip_reset_);
    end
  endtask

  task automatic test_lock_loss_run();
    locked_in = 1'b0;
    tick(); tick();
    checks++;
    if (chip_reset_ !== 1'b1 || reset_state !== 2'd2) begin
      errors++;
      $display("FAIL run_lock_early: chip=%b state=%0d expected 1 2", chip_reset_, reset_state);
    end
    tick();
    checks++;
    if (chip_reset_ !== 1'b0 || reset_state !== 2'd0 || lock_lost !== 1'b1 || reset_count !== 8'd3) begin
      errors++;
      $display("FAIL run_lock: chip=%b state=%0d lost=%b cnt=%0d expected 0 0 1 3",
               chip_reset_, reset_state, lock_lost, reset_count);
    end
    locked_in = 1'b1;
    repeat (14) tick();
    checks++;
    if (reset_state !== 2'd1) begin
      errors++;
      $display("FAIL run_restore14: state=%0d expected 1", reset_state);
    end
    tick();
    checks++;
    if (reset_state !== 2'd2 || chip_reset_ !== 1'b1 || lock_lost !== 1'b1) begin
      errors++;
      $display("FAIL run_restore15: state=%0d chip=%b lost=%b expected 2 1 1", reset_state, chip_reset_, lock_lost);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] ec;
    for (int k = 1; k <= 300; k++) begin
      sw_reset_ = 1'b0;
      repeat (7) tick();
      sw_reset_ = 1'b1;
      repeat (15) tick();
      if (k == 251 || k == 252 || k == 300) begin
        ec = (k == 251) ? 8'd254 : 8'd255;
        checks++;
        if (reset_count !== ec || reset_state !== 2'd2) begin
          errors++;
          $display("FAIL saturate k%0d: cnt=%0d state=%0d expected %0d 2", k, reset_count, reset_state, ec);
        end
      end
    end
  endtask

  task automatic test_async_reset_mid_hold();
    locked_in = 1'b0;
    repeat (3) tick();
    locked_in = 1'b1;
    repeat (9) tick();
    checks++;
    if (reset_state !== 2'd1 || lock_lost !== 1'b1 || reset_count !== 8'd255) begin
      errors++;
      $display("FAIL pre_async: state=%0d lost=%b cnt=%0d expected 1 1 255", reset_state, lock_lost, reset_count);
    end
    #2;
    reset_ = 1'b0;
    #1;
    checks++;
    if (chip_reset_ !== 1'b0 || reset_state !== 2'd0 || lock_lost !== 1'b0 || reset_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: chip=%b state=%0d lost=%b cnt=%0d expected 0 0 0 0",
               chip_reset_, reset_state, lock_lost, reset_count);
    end
  endtask

  task automatic test_lock_filter();
    logic [1:0] es;
    locked_in = 1'b0;
    tick(); tick();
    reset_ = 1'b1; locked_in = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (e == 3) locked_in = 1'b0;
      if (e == 4) locked_in = 1'b1;
      es = (e <= 10) ? 2'd0 : (e <= 18) ? 2'd1 : 2'd2;
      checks++;
      if (reset_state !== es || chip_reset_ !== (e == 19)) begin
        errors++;
        $display("FAIL filter e%0d: state=%0d chip=%b expected state=%0d chip=%b",
                 e, reset_state, chip_reset_, es, (e == 19));
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_switch();
    test_lock_loss_sw_rst();
    test_lock_loss_hold();
    test_lock_loss_run();
    test_saturate();
    test_async_reset_mid_hold();
    test_lock_filter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/chip_reset_ctrl.md
# chip_reset_ctrl

Reset sequencer that sits at the output of the clock-generation stage, consuming the DCM lock indication and the board push-switch to produce the chip-wide system reset. Holds the core in reset until lock is stable, stretches reset for a fixed hold time, then releases it synchronously to `clk`. Re-asserts reset on lock loss or a debounced switch press, and exposes status for debug.

## Interface
- SYNC_STAGES, 2: flops in each input synchronizer (min 2).
- LOCK_FILTER, 16: consecutive high samples of synchronized lock required to declare lock (1..255).
- HOLD_CYCLES, 255: reset-stretch length after lock/switch release (1..255).
- DEBOUNCE_CYCLES, 50000: consecutive stable samples to accept a switch change (1..65535).

- clk  in  1  system clock (DCM CLK0 output)
- reset_  in  1  asynchronous active-low power-on reset
- locked_in  in  1  DCM lock, asynchronous to clk, high = locked
- sw_reset_  in  1  raw push-switch, asynchronous, low = pressed
- chip_reset_  out  1  system reset, active-low, registered
- reset_state  out  2  FSM state: 0 WAIT_LOCK, 1 HOLD, 2 RUN, 3 SW_RST
- lock_lost  out  1  sticky: lock dropped while in RUN
- reset_count  out  8  saturating count of reset events from RUN

## Operation
- reset_ low (async): state WAIT_LOCK, chip_reset_=0, lock_lost=0, reset_count=0, all synchronizer flops, filter/hold/debounce counters and debounced switch (sw_db, 1=pressed) cleared to 0.
- lock_sync, sw_sync: SYNC_STAGES-flop synchronizers; sw_sync is inverted so 1=pressed.
- Lock filter: counter increments each edge lock_sync=1 (saturates), clears on any edge lock_sync=0; lock_ok=1 once LOCK_FILTER consecutive high samples seen.
- Debounce: if sw_sync != sw_db, counter increments; on the DEBOUNCE_CYCLES-th consecutive differing sample sw_db toggles and counter clears; any matching sample clears counter.
- FSM (priority: reset_ > lock loss > switch):
  - WAIT_LOCK: lock_ok=1 -> HOLD (hold counter set 0).
  - HOLD: counter +1 per edge; counter==HOLD_CYCLES-1 -> RUN. lock_sync=0 -> WAIT_LOCK.
  - RUN: lock_sync=0 -> WAIT_LOCK, set lock_lost, reset_count+1. Else sw_db=1 -> SW_RST, reset_count+1.
  - SW_RST: lock_sync=0 -> WAIT_LOCK (no count, no lock_lost). Else sw_db=0 -> HOLD (counter 0).
- chip_reset_ is a flop loaded with (next_state==RUN); high exactly while state==RUN.
- reset_count saturates at 255; lock_lost cleared only by reset_.
- Switch press outside RUN has no effect other than delaying release via SW_RST entry? No: press in WAIT_LOCK/HOLD is ignored; only sw_db level in RUN/SW_RST matters.

## Timing
- Edges counted from first rising clk after reset_ deassertion, locked_in already high: lock_sync=1 at edge SYNC_STAGES; lock_ok=1 at edge SYNC_STAGES+LOCK_FILTER; HOLD entered at edge E=SYNC_STAGES+LOCK_FILTER+1; RUN and chip_reset_=1 at edge E+HOLD_CYCLES (defaults: edge 274).
- Lock loss in RUN: chip_reset_ falls SYNC_STAGES+1 edges after locked_in falls; lock glitches shorter than one clk may be missed (acceptable).
- Switch press in RUN: chip_reset_ falls SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after stable press; release re-enters HOLD after the same latency, RUN HOLD_CYCLES edges later.
- Lock returning during HOLD countdown restarts from WAIT_LOCK filter; no partial credit.
- reset_ assertion mid-sequence forces chip_reset_=0 immediately, without clk.

## Test plan
Parameters SYNC_STAGES=2, LOCK_FILTER=4, HOLD_CYCLES=8, DEBOUNCE_CYCLES=4.
- Power-up: locked_in=1, release reset_ -> chip_reset_=0, reset_state 0 through edge 6, 1 at edge 7, chip_reset_=1 and reset_state=2 at edge 15.
- Lock filter: locked_in high 3 cycles, low 1, then high -> no HOLD entry until 4 consecutive high samples; chip_reset_ stays 0.
- Lock loss in RUN: drop locked_in -> chip_reset_=0 3 edges later, lock_lost=1, reset_count=1; restore lock -> RUN after 2+4+1+8 edges, lock_lost stays 1.
- Switch: 2-cycle bounce pulses ignored; stable press 10 cycles in RUN -> chip_reset_=0 at edge 7 of press, reset_state=3, reset_count+1; release -> HOLD at edge 7, RUN 8 edges later.
- Lock loss during SW_RST and during HOLD -> WAIT_LOCK, reset_count unchanged, lock_lost unchanged.
- 300 switch events -> reset_count saturates at 255; async reset_ pulse mid-HOLD -> all outputs 0 without clock edge.
